// File: rtl/oled_frame_sequencer.sv
// SSD1306 command/frame sequencer feeding a non-stalling I2C write master.
// Sends the init list after power-up, then window + frame transactions on refresh.
module oled_frame_sequencer #(
  parameter int                    ADDR_WIDTH  = 7,
  parameter int                    DATA_WIDTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] SLAVE_ADDR  = 7'h3C,
  parameter int                    FRAME_BYTES = 1024,
  parameter int                    POR_CYCLES  = 270000,
  parameter int                    RETRY_MAX   = 3
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic                  i_refresh,
  input  logic                  i_px_valid,
  input  logic [DATA_WIDTH-1:0] i_px_data,
  output logic                  o_px_ready,
  output logic                  o_frame_done,
  output logic                  o_init_done,
  output logic                  o_error,
  output logic                  o_underrun,
  output logic                  o_start,
  output logic                  o_last,
  output logic                  o_rw,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_ready,
  input  logic                  i_addr_done,
  input  logic                  i_data_done,
  input  logic                  i_rw_failure
);
  localparam int MAXLEN = (FRAME_BYTES + 1 > 26) ? FRAME_BYTES + 1 : 26;
  localparam int IW     = $clog2(MAXLEN);
  localparam int PW     = $clog2(POR_CYCLES + 1);
  localparam int RW     = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);

  typedef enum logic [3:0] {
    POR_WAIT, INIT_REQ, INIT_XFER, READY, WIN_REQ, WIN_XFER, FRM_REQ, FRM_XFER, ERROR
  } state_t;

  state_t                r_state, w_next;
  logic [PW-1:0]         r_por_cnt;
  logic [IW-1:0]         r_idx, w_len;
  logic [RW-1:0]         r_retry;
  logic                  r_addr_ok, r_sent, r_full, r_init_done, r_frame_done, r_underrun;
  logic [DATA_WIDTH-1:0] r_pf, r_frm_byte;
  logic                  w_xfer, w_req, w_fail, w_ack, w_is_last, w_done, w_pf_ok, w_load, w_adv_px;

  function automatic logic [7:0] init_byte(input logic [IW-1:0] i);
    case (int'(i))
      1: return 8'hAE;  2: return 8'hD5;  3: return 8'h80;  4: return 8'hA8;  5: return 8'h3F;
      6: return 8'hD3;  7: return 8'h00;  8: return 8'h40;  9: return 8'h8D; 10: return 8'h14;
      11: return 8'h20; 12: return 8'h00; 13: return 8'hA1; 14: return 8'hC8; 15: return 8'hDA;
      16: return 8'h12; 17: return 8'h81; 18: return 8'hCF; 19: return 8'hD9; 20: return 8'hF1;
      21: return 8'hDB; 22: return 8'h40; 23: return 8'hA4; 24: return 8'hA6; 25: return 8'hAF;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] win_byte(input logic [IW-1:0] i);
    case (int'(i))
      1: return 8'h21; 3: return 8'h7F; 4: return 8'h22; 6: return 8'h07;
      default: return 8'h00;
    endcase
  endfunction

  assign w_xfer    = (r_state == INIT_XFER) || (r_state == WIN_XFER) || (r_state == FRM_XFER);
  assign w_req     = (r_state == INIT_REQ) || (r_state == WIN_REQ) || (r_state == FRM_REQ);
  assign w_fail    = w_xfer && i_rw_failure;
  // Data ACKs only count once the address phase has been acknowledged.
  assign w_ack     = w_xfer && r_addr_ok && i_data_done && !i_rw_failure;
  assign w_is_last = (r_idx == w_len - 1'b1);
  assign w_done    = w_xfer && r_sent && i_ready && !i_rw_failure;
  assign w_pf_ok   = (r_state != POR_WAIT) && (r_state != ERROR);
  assign w_load    = i_px_valid && !r_full && w_pf_ok;
  assign w_adv_px  = w_ack && (r_state == FRM_XFER) && !w_is_last;

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) r_state <= POR_WAIT;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      POR_WAIT: if (r_por_cnt == PW'(POR_CYCLES - 1)) w_next = INIT_REQ;
      INIT_REQ: if (i_ready) w_next = INIT_XFER;
      WIN_REQ:  if (i_ready) w_next = WIN_XFER;
      FRM_REQ:  if (i_ready) w_next = FRM_XFER;
      READY:    if (i_refresh) w_next = WIN_REQ;
      INIT_XFER, WIN_XFER, FRM_XFER: begin
        if (w_fail) begin
          if (r_retry < RW'(RETRY_MAX))
            w_next = (r_state == INIT_XFER) ? INIT_REQ : (r_state == WIN_XFER) ? WIN_REQ : FRM_REQ;
          else
            w_next = ERROR;
        end else if (w_done) begin
          w_next = (r_state == WIN_XFER) ? FRM_REQ : READY;
        end
      end
      default: w_next = r_state;
    endcase
  end

  always_comb begin
    w_len        = IW'(1);
    o_start      = w_req && i_ready;
    o_rw         = 1'b0;
    o_addr       = SLAVE_ADDR;
    o_data       = '0;
    o_error      = (r_state == ERROR);
    o_init_done  = r_init_done;
    o_frame_done = r_frame_done;
    o_underrun   = r_underrun;
    o_px_ready   = !r_full && w_pf_ok;
    case (r_state)
      INIT_REQ, INIT_XFER: begin
        w_len  = IW'(26);
        o_data = DATA_WIDTH'(init_byte(r_idx));
      end
      WIN_REQ, WIN_XFER: begin
        w_len  = IW'(7);
        o_data = DATA_WIDTH'(win_byte(r_idx));
      end
      FRM_REQ, FRM_XFER: begin
        w_len  = IW'(FRAME_BYTES + 1);
        o_data = (r_idx == '0) ? DATA_WIDTH'(8'h40) : r_frm_byte;
      end
      default: ;
    endcase
    o_last = (w_xfer || o_start) && w_is_last;
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_por_cnt    <= '0;
      r_idx        <= '0;
      r_retry      <= '0;
      r_addr_ok    <= 1'b0;
      r_sent       <= 1'b0;
      r_full       <= 1'b0;
      r_pf         <= '0;
      r_frm_byte   <= '0;
      r_init_done  <= 1'b0;
      r_frame_done <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      if (r_state == POR_WAIT) r_por_cnt <= r_por_cnt + 1'b1;
      // Index rests at 0 outside a transfer so each (re)start sends byte 0.
      if (!w_xfer)                  r_idx <= '0;
      else if (w_ack && !w_is_last) r_idx <= r_idx + 1'b1;
      if (!w_xfer)                  r_addr_ok <= 1'b0;
      else if (i_addr_done)         r_addr_ok <= 1'b1;
      if (!w_xfer)                  r_sent <= 1'b0;
      else if (w_ack && w_is_last)  r_sent <= 1'b1;
      if (w_fail)      r_retry <= r_retry + 1'b1;
      else if (w_done) r_retry <= '0;
      if (w_done && r_state == INIT_XFER) r_init_done <= 1'b1;
      r_frame_done <= w_done && (r_state == FRM_XFER);
      // An empty prefetch at pixel advance sends zero rather than stalling the master.
      if (w_adv_px) begin
        r_frm_byte <= r_full ? r_pf : '0;
        if (!r_full) r_underrun <= 1'b1;
      end
      if (w_load) r_pf <= i_px_data;
      r_full <= w_load || (r_full && !w_adv_px);
    end
  end
endmodule

// File: tb/tb_oled_frame_sequencer.sv
// Directed bench: behavioural I2C master model plus table-checked byte streams.
module tb_oled_frame_sequencer;
  localparam int FB  = 16;
  localparam int POR = 20;

  logic       i_clk = 0, i_arst = 1, i_refresh = 0, i_px_valid, o_px_ready;
  logic [7:0] i_px_data, o_data;
  logic [6:0] o_addr;
  logic       o_frame_done, o_init_done, o_error, o_underrun, o_start, o_last, o_rw;
  logic       i_ready, i_addr_done, i_data_done, i_rw_failure;

  oled_frame_sequencer #(.FRAME_BYTES(FB), .POR_CYCLES(POR)) dut (
    .i_clk(i_clk), .i_arst(i_arst), .i_refresh(i_refresh), .i_px_valid(i_px_valid),
    .i_px_data(i_px_data), .o_px_ready(o_px_ready), .o_frame_done(o_frame_done),
    .o_init_done(o_init_done), .o_error(o_error), .o_underrun(o_underrun), .o_start(o_start),
    .o_last(o_last), .o_rw(o_rw), .o_addr(o_addr), .o_data(o_data), .i_ready(i_ready),
    .i_addr_done(i_addr_done), .i_data_done(i_data_done), .i_rw_failure(i_rw_failure));

  always #5 i_clk = ~i_clk;

  int n_cmp = 0, n_bad = 0;
  int n_start = 0, n_fd = 0, start_held = 0;
  int nack_addr = 0, nack_byte = -1;
  int px_cnt = 0, px_stop = 1000;
  bit px_en = 0, hs, prev_start = 0;
  logic [7:0] rx[$];
  bit         lastq[$];

  typedef struct { int pos; logic [7:0] exp_data; bit exp_last; } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge i_clk) begin
    if (o_start) n_start++;
    if (o_start && prev_start) start_held++;
    prev_start = o_start;
    if (o_frame_done) n_fd++;
  end

  // Pixel source: incrementing bytes, valid dropped once px_cnt reaches px_stop.
  initial begin
    i_px_valid = 0; i_px_data = 0;
    forever begin
      @(negedge i_clk); hs = i_px_valid & o_px_ready;
      @(posedge i_clk); #1;
      if (hs) px_cnt++;
      i_px_data  = 8'(px_cnt);
      i_px_valid = px_en && (px_cnt < px_stop);
    end
  end

  task automatic end_txn();
    i_ready = 1; i_addr_done = 0; i_data_done = 0; i_rw_failure = 0;
    #1;
  endtask

  task automatic fail_pulse();
    i_rw_failure = 1; @(posedge i_clk); #1; i_rw_failure = 0;
  endtask

  task automatic run_txn();
    bit fin = 0;
    int b = 0;
    @(posedge i_clk); #1; i_ready = 0;
    @(posedge i_clk); #1;
    if (i_arst) begin end_txn(); return; end
    if (nack_addr > 0) begin nack_addr--; fail_pulse(); end_txn(); return; end
    i_addr_done = 1; @(posedge i_clk); #1; i_addr_done = 0;
    while (!fin && b < 2000) begin
      if (i_arst) break;
      if (b == nack_byte) begin nack_byte = -1; fail_pulse(); end_txn(); return; end
      rx.push_back(o_data); lastq.push_back(o_last); fin = o_last;
      i_data_done = 1; @(posedge i_clk); #1; i_data_done = 0; b++;
      @(posedge i_clk); #1;
    end
    end_txn();
  endtask

  initial begin
    i_ready = 1; i_addr_done = 0; i_data_done = 0; i_rw_failure = 0;
    @(posedge i_clk); #1;
    forever begin
      if (!i_arst && o_start) run_txn();
      else begin @(posedge i_clk); #1; end
    end
  end

  task automatic do_reset();
    i_arst = 1;
    repeat (3) @(negedge i_clk);
    i_arst = 0;
    rx.delete(); lastq.delete(); n_start = 0; n_fd = 0;
  endtask

  task automatic wait_init(input string nm);
    for (int k = 0; k < 1000 && !o_init_done; k++) @(negedge i_clk);
    chk(nm, o_init_done, 1);
  endtask

  task automatic wait_frames(input int n, input string nm);
    for (int k = 0; k < 2000 && n_fd < n; k++) @(negedge i_clk);
    chk(nm, n_fd, n);
  endtask

  initial begin
    logic [7:0] init_b [26] = '{8'h00, 8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40,
                                8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81,
                                8'hCF, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};
    logic [7:0] win_b [7] = '{8'h00, 8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};
    vec_t tv_init[$], tv_frm[$];
    for (int i = 0; i < 26; i++) tv_init.push_back('{i, init_b[i], i == 25});
    for (int i = 0; i < 7; i++)  tv_frm.push_back('{i, win_b[i], i == 6});
    tv_frm.push_back('{7, 8'h40, 0});
    for (int i = 0; i < FB; i++) tv_frm.push_back('{8 + i, 8'(i), i == FB - 1});

    // Reset state
    repeat (2) @(negedge i_clk);
    chk("rst_addr", o_addr, 7'h3C);
    chk("rst_outs", {o_start, o_last, o_rw, o_data, o_px_ready, o_frame_done, o_init_done,
                     o_error, o_underrun}, 0);
    do_reset();

    // Power-on wait then init list
    repeat (POR - 3) @(negedge i_clk);
    chk("por_no_start", n_start, 0);
    wait_init("init_done");
    chk("init_starts", n_start, 1);
    chk("init_len", rx.size(), 26);
    foreach (tv_init[i]) begin
      chk($sformatf("init_byte%0d", tv_init[i].pos), rx[tv_init[i].pos], tv_init[i].exp_data);
      chk($sformatf("init_last%0d", tv_init[i].pos), lastq[tv_init[i].pos], tv_init[i].exp_last);
    end
    chk("rw_tied", o_rw, 0);

    // Window + frame with a full pixel stream
    rx.delete(); lastq.delete(); n_start = 0;
    px_en = 1;
    repeat (4) @(negedge i_clk);
    i_refresh = 1;
    for (int k = 0; k < 200 && n_start < 1; k++) @(negedge i_clk);
    i_refresh = 0;
    wait_frames(1, "frame1_done");
    chk("frame1_starts", n_start, 2);
    chk("frame1_len", rx.size(), 8 + FB);
    foreach (tv_frm[i]) begin
      chk($sformatf("frm_byte%0d", tv_frm[i].pos), rx[tv_frm[i].pos], tv_frm[i].exp_data);
      chk($sformatf("frm_last%0d", tv_frm[i].pos), lastq[tv_frm[i].pos], tv_frm[i].exp_last);
    end
    chk("frame1_underrun", o_underrun, 0);
    repeat (3) @(negedge i_clk);
    chk("frame_done_pulse", n_fd, 1);

    // Pixel stream stalls from pixel 10 of the next frame
    rx.delete(); lastq.delete();
    px_stop = 26;
    i_refresh = 1;
    for (int k = 0; k < 200 && n_start < 3; k++) @(negedge i_clk);
    i_refresh = 0;
    wait_frames(2, "frame2_done");
    for (int i = 0; i < FB; i++)
      chk($sformatf("ur_px%0d", i), rx[8 + i], (i < 10) ? 8'(16 + i) : 8'h00);
    chk("underrun_set", o_underrun, 1);
    px_en = 0;

    // NACK on the third init byte once
    nack_byte = 2;
    do_reset();
    wait_init("nack_init_done");
    chk("nack_starts", n_start, 2);
    chk("nack_len", rx.size(), 28);
    chk("nack_restart0", rx[2], 8'h00);
    chk("nack_restart1", rx[3], 8'hAE);
    chk("nack_lastbyte", rx[27], 8'hAF);
    chk("nack_no_error", o_error, 0);

    // Address NACK on four consecutive attempts
    nack_addr = 4;
    do_reset();
    for (int k = 0; k < 1000 && !o_error; k++) @(negedge i_clk);
    chk("err_set", o_error, 1);
    repeat (100) @(negedge i_clk);
    chk("err_starts", n_start, 4);
    chk("err_sticky", o_error, 1);
    chk("err_no_init", o_init_done, 0);
    chk("err_px_ready", o_px_ready, 0);

    // Reset in the middle of a frame transfer
    nack_addr = 0;
    do_reset();
    wait_init("mid_init");
    rx.delete(); lastq.delete();
    i_refresh = 1;
    for (int k = 0; k < 200 && n_start < 2; k++) @(negedge i_clk);
    i_refresh = 0;
    for (int k = 0; k < 500 && rx.size() < 12; k++) @(negedge i_clk);
    chk("mid_reached", rx.size() >= 12, 1);
    i_arst = 1;
    @(negedge i_clk);
    chk("mid_rst_addr", o_addr, 7'h3C);
    chk("mid_rst_outs", {o_start, o_last, o_data, o_px_ready, o_frame_done, o_init_done,
                         o_error, o_underrun}, 0);
    repeat (2) @(negedge i_clk);
    i_arst = 0;
    rx.delete(); lastq.delete(); n_start = 0; n_fd = 0;
    wait_init("mid_reinit");
    chk("mid_reinit_starts", n_start, 1);
    chk("mid_reinit_len", rx.size(), 26);
    chk("mid_reinit_b1", rx[1], 8'hAE);
    chk("mid_no_frame", n_fd, 0);

    chk("start_never_held", start_held, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
